// File: rtl/pdm_cic_decimator.sv
// rtl/pdm_cic_decimator.sv - second-order CIC decimator turning a 1-bit PDM stream into 8-bit signed PCM
module pdm_cic_decimator #(
    parameter int R_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic       pdm_in,
    output logic [7:0] pcm_out,
    output logic       pcm_valid,
    output logic       pcm_sat
);

    localparam int W     = 2 * R_LOG2 + 1;
    localparam int SHIFT = 2 * R_LOG2 - 8;

    // Mid-scale of the raw comb output (density 0.5) maps to PCM zero.
    localparam logic signed [W:0] BIAS = $signed((W+1)'(1) << (W - 2));
    localparam logic signed [W:0] PMAX = (W+1)'(127);
    localparam logic signed [W:0] PMIN = -(W+1)'(128);

    logic [W-1:0]      i1, i2, d1, d2;
    logic [W-1:0]      c1, c2;
    logic [R_LOG2-1:0] cnt;
    logic [1:0]        warm;
    logic              valid_r;
    logic              tick;
    logic signed [W:0] diff, scaled;
    logic [7:0]        pcm_next;
    logic              sat_next;

    assign tick = en && (cnt == '1);
    assign c1   = i2 - d1;
    assign c2   = c1 - d2;

    assign diff   = $signed({1'b0, c2}) - BIAS;
    assign scaled = diff >>> SHIFT;

    always_comb begin
        pcm_next = scaled[7:0];
        sat_next = 1'b0;
        if (scaled > PMAX) begin
            pcm_next = 8'h7f;
            sat_next = 1'b1;
        end else if (scaled < PMIN) begin
            pcm_next = 8'h80;
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1      <= '0;
            i2      <= '0;
            d1      <= '0;
            d2      <= '0;
            cnt     <= '0;
            warm    <= '0;
            pcm_out <= '0;
            pcm_sat <= 1'b0;
            valid_r <= 1'b0;
        end else if (clr) begin
            i1      <= '0;
            i2      <= '0;
            d1      <= '0;
            d2      <= '0;
            cnt     <= '0;
            warm    <= '0;
            pcm_out <= '0;
            pcm_sat <= 1'b0;
            valid_r <= 1'b0;
        end else if (en) begin
            i1      <= i1 + {{(W-1){1'b0}}, pdm_in};
            i2      <= i2 + i1;
            cnt     <= cnt + R_LOG2'(1);
            valid_r <= 1'b0;
            if (tick) begin
                d1 <= i2;
                d2 <= c1;
                // The first two comb outputs still contain start-up transients.
                if (warm == 2'd2) begin
                    pcm_out <= pcm_next;
                    pcm_sat <= sat_next;
                    valid_r <= 1'b1;
                end else begin
                    warm <= warm + 2'd1;
                end
            end
        end
    end

    // A strobe pending across disabled cycles surfaces on the next enabled cycle.
    assign pcm_valid = valid_r & en;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb/tb_pdm_cic_decimator.sv - scoreboard bench for pdm_cic_decimator with R_LOG2=4
module tb_pdm_cic_decimator;

    localparam int R = 16;

    typedef struct {
        int out;
        int sat;
        int tol;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       pdm_in = 1'b0;
    logic [7:0] pcm_out;
    logic       pcm_valid;
    logic       pcm_sat;

    exp_t sbq[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   ecnt = 0;
    int   last_ecnt = 0;
    bit   first = 1'b1;

    pdm_cic_decimator #(.R_LOG2(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .pdm_in    (pdm_in),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid),
        .pcm_sat   (pcm_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
        tests++;
        assert (obs >= exp - tol && obs <= exp + tol) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    // Enabled edges since the last reset/clear, as the DUT should see them.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            ecnt  = 0;
            first = 1'b1;
        end else if (en) begin
            ecnt++;
        end
    end

    always @(negedge clk) begin
        if (pcm_valid) begin
            check("valid_while_en", int'(en), 1);
            check("sb_nonempty", int'(sbq.size() > 0), 1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check_tol("pcm_out", int'($signed(pcm_out)), e.out, e.tol);
                check("pcm_sat", int'(pcm_sat), e.sat);
            end
            if (first) check("first_latency", ecnt, 3 * R);
            else       check("strobe_spacing", ecnt - last_ecnt, R);
            first     = 1'b0;
            last_ecnt = ecnt;
        end
    end

    task automatic push(input int n, input int out, input int sat, input int tol);
        exp_t x;
        x.out = out;
        x.sat = sat;
        x.tol = tol;
        for (int i = 0; i < n; i++) sbq.push_back(x);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        en  = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic run_pat(input logic [15:0] pat, input int plen, input int ncyc);
        logic [15:0] p;
        p  = pat;
        en = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            pdm_in = p[k % plen];
            @(posedge clk); #1;
        end
    endtask

    task automatic drained(input string tag);
        @(negedge clk); #1;
        check(tag, sbq.size(), 0);
    endtask

    task automatic seg(input string tag, input logic [15:0] pat, input int plen,
                       input int nwin, input int out, input int sat);
        push(nwin - 2, out, sat, 0);
        pulse_clr();
        run_pat(pat, plen, nwin * R);
        drained(tag);
    endtask

    initial begin
        int k;
        int guard;
        int acc;
        int nxt;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pcm_out", int'(pcm_out), 0);
        check("rst_pcm_valid", int'(pcm_valid), 0);
        check("rst_pcm_sat", int'(pcm_sat), 0);
        rst_n = 1'b1;

        // Constant 1 straight out of reset: first strobe after 48 cycles, clipped.
        push(3, 127, 1, 0);
        run_pat(16'h0001, 1, 5 * R);
        drained("drain_ones");

        seg("drain_zeros", 16'h0000, 1, 5, -128, 0);
        seg("drain_alt",   16'h0001, 2, 5, 0, 0);
        seg("drain_1110",  16'h0007, 4, 5, 64, 0);
        seg("drain_1000",  16'h0001, 4, 5, -64, 0);

        // First-order sigma-delta NCO loopback, input word 0x40.
        push(3, 64, 0, 1);
        pulse_clr();
        acc = 0;
        for (int i = 0; i < 5 * R; i++) begin
            nxt    = acc + 8'h40 + 128;
            pdm_in = nxt[8];
            acc    = nxt & 255;
            @(posedge clk); #1;
        end
        drained("drain_nco");

        // Random 50% enable with a 1,1,1,0 input.
        push(4, 64, 0, 0);
        pulse_clr();
        k = 0;
        guard = 0;
        while (k < 6 * R && guard < 4000) begin
            en     = 1'($urandom_range(0, 1));
            pdm_in = (k % 4 != 3);
            @(posedge clk); #1;
            if (en) k++;
            guard++;
        end
        check("en_rand_budget", k, 6 * R);
        en = 1'b1;
        drained("drain_en_rand");

        // clr mid-window after one strobe.
        push(1, 64, 0, 0);
        pulse_clr();
        run_pat(16'h0007, 4, 3 * R + 8);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_pcm_out", int'(pcm_out), 0);
        check("clr_pcm_valid", int'(pcm_valid), 0);
        drained("drain_clr_mid");

        // clr landing on what would be the first valid tick.
        run_pat(16'h0007, 4, 3 * R - 1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_tick_valid", int'(pcm_valid), 0);
        check("clr_tick_out", int'(pcm_out), 0);
        push(2, -64, 0, 0);
        run_pat(16'h0001, 4, 4 * R);
        drained("drain_after_clr");

        // Async reset while a strobe is being presented.
        push(1, 64, 0, 0);
        pulse_clr();
        run_pat(16'h0007, 4, 4 * R);
        check("valid_before_rst", int'(pcm_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_pcm_valid", int'(pcm_valid), 0);
        check("arst_pcm_out", int'(pcm_out), 0);
        check("arst_pcm_sat", int'(pcm_sat), 0);
        drained("drain_arst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(2, 0, 0, 0);
        run_pat(16'h0001, 2, 4 * R);
        drained("drain_after_arst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pdm_cic_decimator.md
Name: pdm_cic_decimator

Overview:
- Second-order CIC decimator that consumes the 1-bit PDM stream produced by the first-order sigma-delta NCO stage.
- Reconstructs 8-bit signed PCM samples at clk/R, with a one-cycle valid strobe and a saturation flag.
- Used for on-chip loopback: NCO PDM output feeds pdm_in, and pcm_out can be observed or compared against the NCO input word.

Parameters:
- R_LOG2, 4, log2 of the decimation ratio R = 2^R_LOG2. Legal range 4..7.
- Derived: W = 2*R_LOG2+1, the internal datapath width. SHIFT = 2*R_LOG2-8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  clock enable. When low, all state holds.
- clr  in  1  synchronous clear. Same effect as reset; takes priority over en.
- pdm_in  in  1  PDM bit, unsigned 0/1, sampled every enabled cycle.
- pcm_out  out  8  signed PCM sample. Held between strobes.
- pcm_valid  out  1  one-cycle strobe: pcm_out/pcm_sat updated this cycle.
- pcm_sat  out  1  high when the current pcm_out value was clipped.

Behaviour:
- Reset (rst_n low, async) or clr (sync):
  - i1, i2, d1, d2, cnt, warm all set to 0.
  - pcm_out=0, pcm_valid=0, pcm_sat=0.
- en=0 and clr=0: every register holds, and pcm_valid=0.
- Integrators, each enabled cycle, with all arithmetic modulo 2^W (wrap is intended and required):
  - i1 <= i1 + pdm_in.
  - i2 <= i2 + i1, using the pre-edge value of i1.
- Decimation counter cnt (R_LOG2 bits):
  - Increments each enabled cycle and wraps R-1 -> 0.
  - tick = en & (cnt == R-1).
- On tick, comb stage, combinational from the pre-edge i2, all modulo 2^W:
  - c1 = i2 - d1; c2 = c1 - d2.
  - d1 <= i2; d2 <= c1.
- Scaling of c2 (treated as unsigned raw value, 0..2^(W-1)):
  - s = (raw - 2^(W-2)) >>> SHIFT, computed in signed arithmetic.
  - Saturate s to [-128, 127]. pcm_sat = 1 iff clipping occurred; otherwise pcm_sat = 0.
  - Only raw = 2^(W-1) (pdm density 1.0) can clip.
- Warm-up:
  - 2-bit counter warm suppresses the first 2 ticks after reset or clr. warm increments on each tick until it reaches 2, then stays there.
  - Tick with warm < 2: d1/d2 update as normal; pcm_out, pcm_sat and pcm_valid do not change.
  - Tick with warm == 2: pcm_out and pcm_sat are registered at the tick edge; pcm_valid is 1 for exactly the following cycle.
- Latency:
  - The first pcm_valid is high in the cycle after the 3rd tick, i.e. after 3R enabled cycles.
  - Subsequent strobes are spaced exactly R enabled cycles apart.
- Steady state with constant pdm density d: raw = R^2 * d exactly, from the first valid sample onward.
- en low across a tick boundary: the tick is deferred until the next enabled cycle with cnt == R-1. No sample is lost or duplicated.
- clr and tick in the same cycle: clr wins. No strobe, and warm-up restarts.
- Async reset mid-sample: the partial window is discarded, and pcm_valid deasserts immediately.

Test Plan (R_LOG2=4, en=1 unless stated):
- pdm_in=1 constant -> first pcm_valid in cycle 48 after reset release; pcm_out=127, pcm_sat=1; strobes every 16 cycles thereafter.
- pdm_in=0 constant -> pcm_out=-128 (0x80), pcm_sat=0, on every valid sample.
- pdm_in alternating 1,0,... -> pcm_out=0 on all valid samples. Pattern 1,1,1,0 repeating -> pcm_out=64. Pattern 1,0,0,0 repeating -> pcm_out=-64.
- Loopback from the NCO stage, driving it with a constant input of 0x40 (density 0.75) -> pcm_out=64 ±1 on all valid samples after warm-up.
- en toggled with a random 50% duty during a constant-1,1,1,0 input -> sample values unchanged (64); strobe spacing equals 16 enabled cycles; no pcm_valid while en=0.
- clr asserted mid-stream, and separately rst_n pulsed low mid-window -> pcm_out=0 and pcm_valid=0 immediately; the next strobe comes 48 enabled cycles after release, with the correct value.
